io_pwr_seq: RTL
===============

IO_PWR_SEQ -- requirements
Module: io_pwr_seq

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 16, is the number of consecutive cycles pwr_good must stay high before ramp starts (legal range 2..255).
REQ-002 Parameter STAGE_GAP, default 8, is the number of cycles between successive pad-group enables (legal range 1..255).
REQ-003 Parameter NUM_GRP, default 4, is the number of pad groups sequenced (legal range 1..16).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port seq_en_i, input, 1 bit: software/boot request to power the IO ring; synchronous to clk.
REQ-007 Port pwr_good_i, input, 1 bit: VDDIO power-good from the analog pad ring; asynchronous to clk.
REQ-008 Port grp_en_o, output, NUM_GRP bits: per-group pad enable; thermometer-coded, bit 0 first.
REQ-009 Port io_ready_o, output, 1 bit: all groups enabled and settled.
REQ-010 Port fault_o, output, 1 bit: sticky power-loss-while-enabled indication.
REQ-011 Port state_o, output, 3 bits: current FSM state encoding for debug/status.

Function
REQ-012 pwr_good_i SHALL pass through a 2-flop synchronizer (reset value 0); "pg" below denotes the synchronizer output.
REQ-013 FSM states and state_o encodings SHALL be: OFF=0, DEBOUNCE=1, RAMP=2, READY=3, FAULT=4.
REQ-014 OFF: grp_en_o=0, io_ready_o=0; on seq_en_i=1 and pg=1, go to DEBOUNCE and clear the counter.
REQ-015 DEBOUNCE: counter increments each cycle; pg=0 returns to OFF with the counter cleared.
REQ-016 The DEBOUNCE-to-RAMP transition SHALL occur on the edge where the counter equals DEBOUNCE_CYC-1, so that DEBOUNCE lasts exactly DEBOUNCE_CYC cycles.
REQ-017 On the same edge as REQ-016, grp_en_o[0] SHALL be set.
REQ-018 RAMP: grp_en_o[k] SHALL be set exactly STAGE_GAP cycles after grp_en_o[k-1], for k=1..NUM_GRP-1.
REQ-019 Once set, grp_en_o bits SHALL be cleared only by REQ-021, REQ-022 or reset.
REQ-020 RAMP SHALL go to READY STAGE_GAP cycles after the last group is enabled; io_ready_o=1 only in READY.
REQ-021 In DEBOUNCE, RAMP or READY, seq_en_i=0 SHALL go to OFF and clear all grp_en_o bits on the next edge.
REQ-022 In RAMP or READY, pg=0 with seq_en_i=1 SHALL go to FAULT, set fault_o, and clear all grp_en_o bits on the next edge.
REQ-023 When seq_en_i=0 and pg=0 occur in the same cycle, seq_en_i=0 SHALL take priority: go to OFF, and fault_o remains 0.
REQ-024 FAULT: grp_en_o=0, io_ready_o=0, fault_o=1; pg returning high SHALL NOT leave FAULT.
REQ-025 FAULT SHALL exit to OFF only when seq_en_i=0; fault_o clears on that edge.
REQ-026 The counter SHALL be 8 bits wide and SHALL be cleared on every state change; it SHALL never wrap within a state.
REQ-027 All outputs SHALL be registered (no combinational path from inputs to outputs).
REQ-028 Unused state encodings (5..7) SHALL recover to OFF on the next edge.

Reset
REQ-029 While rst=1, the following SHALL hold asynchronously: state=OFF, counter=0, synchronizer flops=0, grp_en_o=0, io_ready_o=0, fault_o=0, state_o=0.
REQ-030 Reset asserted mid-ramp SHALL drop all enables immediately, without waiting for a clock edge.
REQ-031 After rst deasserts, the sequence SHALL restart from OFF, requiring the full debounce again.

Verification
REQ-032 Defaults, seq_en_i=1, pwr_good_i=1 from reset release -> DEBOUNCE entered 3 cycles after release; grp_en_o steps 0001/0011/0111/1111 at +16/+24/+32/+40 cycles after DEBOUNCE entry; io_ready_o=1 at +48.
REQ-033 pwr_good_i low for 1 cycle at DEBOUNCE count 10 -> returns to OFF; grp_en_o stays 0; a full 16-cycle debounce is required after pg returns.
REQ-034 pwr_good_i dropped in READY -> FAULT with grp_en_o=0 and fault_o=1 within 3 cycles; pg restored -> remains FAULT; seq_en_i=0 -> OFF, fault_o=0.
REQ-035 seq_en_i and pwr_good_i dropped in the same cycle during RAMP -> OFF, fault_o stays 0.
REQ-036 rst pulsed while grp_en_o=0011 -> all outputs 0 before the next clk edge; the full sequence repeats after release.
REQ-037 NUM_GRP=1, STAGE_GAP=1, DEBOUNCE_CYC=2 -> grp_en_o=1 two cycles after DEBOUNCE entry; io_ready_o one cycle later.

Source files
------------

// File: rtl/io_pwr_seq.sv
// IO-ring power sequencer: debounces VDDIO power-good, then enables pad groups
// one after another, and latches a fault if power drops while the ring is enabled.
module io_pwr_seq #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int STAGE_GAP    = 8,
    parameter int NUM_GRP      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seq_en_i,
    input  logic               pwr_good_i,
    output logic [NUM_GRP-1:0] grp_en_o,
    output logic               io_ready_o,
    output logic               fault_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_RAMP     = 3'd2,
        ST_READY    = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYC - 1);
    localparam logic [7:0] GAP_LAST = 8'(STAGE_GAP - 1);

    logic               r_sync1;
    logic               r_sync2;
    state_t             r_state;
    logic [7:0]         r_cnt;
    logic [NUM_GRP-1:0] r_grp_en;
    logic               r_ready;
    logic               r_fault;

    logic               w_pg;
    state_t             w_state_nxt;
    logic [7:0]         w_cnt_nxt;
    logic [NUM_GRP-1:0] w_grp_en_nxt;
    logic               w_ready_nxt;
    logic               w_fault_nxt;

    assign w_pg = r_sync2;

    // Two-flop synchronizer for the asynchronous power-good input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwr_good_i;
            r_sync2 <= r_sync1;
        end
    end

    // State register together with the registered outputs and stage counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_OFF;
            r_cnt    <= 8'd0;
            r_grp_en <= '0;
            r_ready  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_grp_en <= w_grp_en_nxt;
            r_ready  <= w_ready_nxt;
            r_fault  <= w_fault_nxt;
        end
    end

    // Next-state logic; a software disable always outranks a power-loss fault
    always_comb begin
        w_state_nxt = ST_OFF;
        case (r_state)
            ST_OFF: begin
                if (seq_en_i && w_pg) w_state_nxt = ST_DEBOUNCE;
                else                  w_state_nxt = ST_OFF;
            end
            ST_DEBOUNCE: begin
                if (!seq_en_i || !w_pg)  w_state_nxt = ST_OFF;
                else if (r_cnt == DB_LAST) w_state_nxt = ST_RAMP;
                else                     w_state_nxt = ST_DEBOUNCE;
            end
            ST_RAMP: begin
                if (!seq_en_i)       w_state_nxt = ST_OFF;
                else if (!w_pg)      w_state_nxt = ST_FAULT;
                else if ((r_cnt == GAP_LAST) && r_grp_en[NUM_GRP-1])
                                     w_state_nxt = ST_READY;
                else                 w_state_nxt = ST_RAMP;
            end
            ST_READY: begin
                if (!seq_en_i)  w_state_nxt = ST_OFF;
                else if (!w_pg) w_state_nxt = ST_FAULT;
                else            w_state_nxt = ST_READY;
            end
            ST_FAULT: begin
                if (!seq_en_i) w_state_nxt = ST_OFF;
                else           w_state_nxt = ST_FAULT;
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    // Output/counter next values; the counter restarts per stage and saturates elsewhere
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_grp_en_nxt = '0;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = 8'd0;
        end else if ((r_state == ST_RAMP) && (r_cnt == GAP_LAST)) begin
            w_cnt_nxt = 8'd0;
        end else if (r_cnt != 8'hFF) begin
            w_cnt_nxt = r_cnt + 8'd1;
        end else begin
            w_cnt_nxt = r_cnt;
        end

        case (w_state_nxt)
            ST_RAMP: begin
                if (r_state != ST_RAMP)      w_grp_en_nxt = NUM_GRP'(1);
                else if (r_cnt == GAP_LAST)  w_grp_en_nxt = (r_grp_en << 1) | NUM_GRP'(1);
                else                         w_grp_en_nxt = r_grp_en;
            end
            ST_READY: w_grp_en_nxt = r_grp_en;
            default:  w_grp_en_nxt = '0;
        endcase

        w_ready_nxt = (w_state_nxt == ST_READY);
        w_fault_nxt = (w_state_nxt == ST_FAULT);
    end

    assign grp_en_o   = r_grp_en;
    assign io_ready_o = r_ready;
    assign fault_o    = r_fault;
    assign state_o    = r_state;

endmodule
